// File: rtl/sync_fifo_flex_if.sv
// sync_fifo_flex_if: producer/consumer bundle for sync_fifo_flex.
//   master : the block that drives the FIFO (data_in, wr_en, rd_en, err_clr)
//   slave  : the FIFO itself (data_out, handshake pulses, level flags,
//            count, sticky error flags)
// CW is derived from FIFO_DEPTH so it always matches the FIFO's count width.
interface sync_fifo_flex_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [FIFO_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic                  err_clr;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CW-1:0]         count;
  logic                  overflow_sticky;
  logic                  underflow_sticky;

  modport master (
    output data_in, wr_en, rd_en, err_clr,
    input  data_out, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, count, overflow_sticky, underflow_sticky
  );

  modport slave (
    input  data_in, wr_en, rd_en, err_clr,
    output data_out, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, count, overflow_sticky, underflow_sticky
  );
endinterface

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO of any depth (non-power-of-two allowed),
// programmable almost-full/almost-empty levels, optional first-word-fall-through.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset (clears pointers, count, pulses,
//            stickies and data_out; memory is left as-is)
//   bus    : sync_fifo_flex_if.slave -- write/read requests, data, flags,
//            count, registered wr_ack/overflow/underflow pulses, sticky errors
module sync_fifo_flex #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = 0,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  sync_fifo_flex_if.slave   bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  full_w, empty_w;
  logic                  rd_acc, wr_acc;
  logic                  ovf_n, udf_n;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths never index past the end.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_w  = (cnt == CW'(FIFO_DEPTH));
  assign empty_w = (cnt == '0);

  // A read frees a slot in the same edge, so a full FIFO can still take a write.
  assign rd_acc = bus.rd_en && !empty_w;
  assign wr_acc = bus.wr_en && (!full_w || rd_acc);
  assign ovf_n  = bus.wr_en && !wr_acc;
  assign udf_n  = bus.rd_en && !rd_acc;

  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      cnt                  <= '0;
      bus.wr_ack           <= 1'b0;
      bus.overflow         <= 1'b0;
      bus.underflow        <= 1'b0;
      bus.overflow_sticky  <= 1'b0;
      bus.underflow_sticky <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      bus.wr_ack    <= wr_acc;
      bus.overflow  <= ovf_n;
      bus.underflow <= udf_n;
      // New error in the same cycle as err_clr keeps the flag set.
      bus.overflow_sticky  <= ovf_n || (bus.overflow_sticky  && !bus.err_clr);
      bus.underflow_sticky <= udf_n || (bus.underflow_sticky && !bus.err_clr);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always presented; zero while nothing is stored.
      assign bus.data_out = empty_w ? '0 : mem[rd_ptr];
    end else begin : g_std
      logic [FIFO_WIDTH-1:0] dout_q;
      always_ff @(posedge clk) begin
        if (!rst_n)      dout_q <= '0;
        else if (rd_acc) dout_q <= mem[rd_ptr];
      end
      assign bus.data_out = dout_q;
    end
  endgenerate

  assign bus.count       = cnt;
  assign bus.full        = full_w;
  assign bus.empty       = empty_w;
  assign bus.almostfull  = (cnt >= CW'(AF_LEVEL)) && !full_w;
  assign bus.almostempty = (cnt <= CW'(AE_LEVEL)) && !empty_w;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: two instances -- standard read, DEPTH=8 (AF 7, AE 1) and
// FWFT, DEPTH=5 (AF 3, AE 2). Each has a queue holding the words the bench
// expects to come out; words are pushed when a write is driven and popped and
// compared when the FIFO presents them.
module tb_sync_fifo_flex;
  logic gclk = 1'b0;
  logic rst_s, rst_f;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 gclk = ~gclk;

  sync_fifo_flex_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) si ();
  sync_fifo_flex_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) fi ();

  sync_fifo_flex #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1), .FWFT(0))
    u_std (.clk(gclk), .rst_n(rst_s), .bus(si.slave));
  sync_fifo_flex #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(2), .FWFT(1))
    u_fw  (.clk(gclk), .rst_n(rst_f), .bus(fi.slave));

  logic [15:0] sq[$];
  logic [15:0] fq[$];
  logic [15:0] s_dout;
  logic        s_ovs, s_uds, f_ovs, f_uds;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic std_check(input logic ack, input logic ovf, input logic udf);
    int n = sq.size();
    chk("s_wr_ack",    32'(si.wr_ack),      32'(ack));
    chk("s_overflow",  32'(si.overflow),    32'(ovf));
    chk("s_underflow", 32'(si.underflow),   32'(udf));
    chk("s_count",     32'(si.count),       n);
    chk("s_full",      32'(si.full),        32'(n == 8));
    chk("s_empty",     32'(si.empty),       32'(n == 0));
    chk("s_afull",     32'(si.almostfull),  32'(n >= 7 && n != 8));
    chk("s_aempty",    32'(si.almostempty), 32'(n <= 1 && n != 0));
    chk("s_data_out",  32'(si.data_out),    32'(s_dout));
    chk("s_ovf_stk",   32'(si.overflow_sticky),  32'(s_ovs));
    chk("s_udf_stk",   32'(si.underflow_sticky), 32'(s_uds));
  endtask

  task automatic fw_check(input logic ack, input logic ovf, input logic udf);
    int n = fq.size();
    chk("f_wr_ack",    32'(fi.wr_ack),      32'(ack));
    chk("f_overflow",  32'(fi.overflow),    32'(ovf));
    chk("f_underflow", 32'(fi.underflow),   32'(udf));
    chk("f_count",     32'(fi.count),       n);
    chk("f_full",      32'(fi.full),        32'(n == 5));
    chk("f_empty",     32'(fi.empty),       32'(n == 0));
    chk("f_afull",     32'(fi.almostfull),  32'(n >= 3 && n != 5));
    chk("f_aempty",    32'(fi.almostempty), 32'(n <= 2 && n != 0));
    chk("f_data_out",  32'(fi.data_out),    (n != 0) ? 32'(fq[0]) : 32'd0);
    chk("f_ovf_stk",   32'(fi.overflow_sticky),  32'(f_ovs));
    chk("f_udf_stk",   32'(fi.underflow_sticky), 32'(f_uds));
  endtask

  task automatic std_step(input logic we, input logic re, input logic [15:0] d, input logic ec);
    int   n    = sq.size();
    logic racc = re && (n != 0);
    logic wacc = we && ((n != 8) || racc);
    si.wr_en = we; si.rd_en = re; si.data_in = d; si.err_clr = ec;
    @(posedge gclk); #1;
    if (racc) s_dout = sq.pop_front();
    if (wacc) sq.push_back(d);
    s_ovs = (we && !wacc) || (s_ovs && !ec);
    s_uds = (re && !racc) || (s_uds && !ec);
    si.wr_en = 1'b0; si.rd_en = 1'b0; si.err_clr = 1'b0;
    std_check(wacc, we && !wacc, re && !racc);
  endtask

  task automatic fw_step(input logic we, input logic re, input logic [15:0] d, input logic ec);
    int   n    = fq.size();
    logic racc = re && (n != 0);
    logic wacc = we && ((n != 5) || racc);
    fi.wr_en = we; fi.rd_en = re; fi.data_in = d; fi.err_clr = ec;
    @(posedge gclk); #1;
    if (racc) void'(fq.pop_front());
    if (wacc) fq.push_back(d);
    f_ovs = (we && !wacc) || (f_ovs && !ec);
    f_uds = (re && !racc) || (f_uds && !ec);
    fi.wr_en = 1'b0; fi.rd_en = 1'b0; fi.err_clr = 1'b0;
    fw_check(wacc, we && !wacc, re && !racc);
  endtask

  // Reset held for one edge while a write is requested: the write must be dropped.
  task automatic std_rst(input logic we, input logic [15:0] d);
    rst_s = 1'b0; si.wr_en = we; si.data_in = d;
    @(posedge gclk); #1;
    rst_s = 1'b1; si.wr_en = 1'b0;
    sq.delete(); s_dout = '0; s_ovs = 1'b0; s_uds = 1'b0;
    std_check(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_s = 1'b0; rst_f = 1'b0;
    si.wr_en = 1'b0; si.rd_en = 1'b0; si.err_clr = 1'b0; si.data_in = '0;
    fi.wr_en = 1'b0; fi.rd_en = 1'b0; fi.err_clr = 1'b0; fi.data_in = '0;
    s_dout = '0; s_ovs = 1'b0; s_uds = 1'b0; f_ovs = 1'b0; f_uds = 1'b0;
    repeat (2) @(posedge gclk);
    #1;
    rst_s = 1'b1; rst_f = 1'b1;
    std_check(1'b0, 1'b0, 1'b0);
    fw_check(1'b0, 1'b0, 1'b0);

    // Standard mode: fill, overflow, clear, drain in order.
    for (int i = 1; i <= 8; i++) std_step(1'b1, 1'b0, 16'(i), 1'b0);
    std_step(1'b1, 1'b0, 16'h0009, 1'b0);
    std_step(1'b0, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 8; i++) std_step(1'b0, 1'b1, 16'h0000, 1'b0);

    // Full with simultaneous write/read; 0xBEEF must come out last.
    for (int i = 0; i < 8; i++) std_step(1'b1, 1'b0, 16'h0100 + 16'(i), 1'b0);
    std_step(1'b1, 1'b1, 16'hBEEF, 1'b0);
    for (int i = 0; i < 8; i++) std_step(1'b0, 1'b1, 16'h0000, 1'b0);

    // Empty with simultaneous write/read: read rejected, then err_clr.
    std_step(1'b1, 1'b1, 16'h00AA, 1'b0);
    std_step(1'b0, 1'b0, 16'h0000, 1'b1);
    std_step(1'b0, 1'b1, 16'h0000, 1'b0);

    // Mid-stream reset with a pending write.
    for (int i = 0; i < 4; i++) std_step(1'b1, 1'b0, 16'h0A00 + 16'(i), 1'b0);
    std_rst(1'b1, 16'h7777);
    std_step(1'b1, 1'b0, 16'h0123, 1'b0);
    std_step(1'b0, 1'b1, 16'h0000, 1'b0);

    repeat (80) std_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         16'($urandom), 1'($urandom_range(0, 7) == 0));

    // FWFT: fall-through, fill, wrap with simultaneous ops, drain, underflow.
    fw_step(1'b1, 1'b0, 16'h0011, 1'b0);
    for (int i = 2; i <= 5; i++) fw_step(1'b1, 1'b0, 16'h0010 + 16'(i), 1'b0);
    fw_step(1'b1, 1'b0, 16'h0099, 1'b0);
    for (int i = 0; i < 7; i++) fw_step(1'b1, 1'b1, 16'h0020 + 16'(i), 1'b0);
    for (int i = 0; i < 5; i++) fw_step(1'b0, 1'b1, 16'h0000, 1'b0);
    fw_step(1'b0, 1'b1, 16'h0000, 1'b0);
    fw_step(1'b0, 1'b0, 16'h0000, 1'b1);

    repeat (80) fw_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        16'($urandom), 1'($urandom_range(0, 7) == 0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
Second-generation synchronous FIFO for the FIFO verification environment. It generalises the legacy fixed-flag FIFO with any depth (including non-power-of-two), programmable almost-full/almost-empty levels, and a selectable first-word-fall-through (FWFT) read mode. It also adds an occupancy count output and sticky error flags cleared by software. It is a drop-in storage block between a producer and consumer on one clock domain.

Parameters:
FIFO_WIDTH, 16, data word width in bits (>=1)
FIFO_DEPTH, 8, number of entries (>=2, any integer)
AF_LEVEL, FIFO_DEPTH-1, almostfull asserts when count >= AF_LEVEL and FIFO not full (1..FIFO_DEPTH-1)
AE_LEVEL, 1, almostempty asserts when count <= AE_LEVEL and FIFO not empty (1..FIFO_DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
CW, $clog2(FIFO_DEPTH+1), count width (derived, not overridden)

Ports:
clk  input  1  clock; all logic on the rising edge
rst_n  input  1  synchronous active-low reset
data_in  input  FIFO_WIDTH  write data
wr_en  input  1  write request
rd_en  input  1  read request (pop, in FWFT mode)
err_clr  input  1  clears the sticky error flags
data_out  output  FIFO_WIDTH  read data
wr_ack  output  1  registered pulse: previous-cycle write accepted
overflow  output  1  registered pulse: previous-cycle write rejected (full)
underflow  output  1  registered pulse: previous-cycle read rejected (empty)
full  output  1  count == FIFO_DEPTH
empty  output  1  count == 0
almostfull  output  1  (count >= AF_LEVEL) && !full
almostempty  output  1  (count <= AE_LEVEL) && !empty
count  output  CW  current occupancy
overflow_sticky  output  1  set by any overflow; held until err_clr
underflow_sticky  output  1  set by any underflow; held until err_clr

Behaviour:
- Reset (rst_n=0 at a clk edge; overrides all other inputs):
  - Pointers, count, data_out, wr_ack, overflow, underflow, both sticky flags -> 0.
  - Resulting flags: empty=1, full=0, almostfull=0, almostempty=0.
  - Memory contents are not reset.
  - Reset mid-stream discards all stored words.
- Accept rules, evaluated on pre-edge count:
  - Write accepted when wr_en && (!full || rd_accepted).
  - Read accepted when rd_en && !empty.
- Simultaneous wr_en and rd_en:
  - Full: both accepted; count unchanged; wr_ack=1; overflow=0.
  - Empty: write accepted, read rejected; underflow=1; count +1.
  - Otherwise: both accepted; count unchanged.
- Count: +1 on write-only, -1 on read-only, else unchanged. It never exceeds FIFO_DEPTH and never goes below 0.
- Pointers: wr_ptr and rd_ptr wrap from FIFO_DEPTH-1 to 0. This must be correct for non-power-of-two depth.
- full, empty, almostfull, almostempty: combinational from registered count. They reflect state the cycle after the causing edge.
- Pulse outputs:
  - wr_ack, overflow and underflow are registered and valid for exactly one cycle after the request edge.
  - All three are 0 on cycles with no corresponding request.
  - overflow = wr_en && !write_accepted.
  - underflow = rd_en && !rd_accepted.
- Standard mode (FWFT=0):
  - data_out is registered and loads mem[rd_ptr] on an accepted read; one-cycle read latency.
  - data_out holds its value on rejected or absent reads.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] whenever !empty. A word written into an empty FIFO is visible the cycle after the write edge.
  - rd_en pops the head; the next word appears the following cycle.
  - data_out is 0 while empty.
- Sticky flags:
  - Set on the same edge that sets overflow or underflow.
  - err_clr=1 clears them; a same-cycle new error wins (flag stays 1).

Test Plan:
- Reset then idle, DEPTH=8 -> empty=1, count=0, all pulses and stickies 0, data_out=0.
- Standard mode: write 0x0001..0x0008 -> full=1 after 8th write; almostfull=1 at count=7 only. 9th write -> overflow=1, wr_ack=0, overflow_sticky=1. Eight reads return 0x0001..0x0008 in order, one cycle after each rd_en.
- Full, wr_en=rd_en=1 with data_in=0xBEEF -> wr_ack=1, overflow=0, count stays 8. 0xBEEF is read last after draining.
- Empty, wr_en=rd_en=1 with data_in=0x00AA -> underflow=1, wr_ack=1, count=1. err_clr=1 next cycle -> underflow_sticky=0.
- FWFT=1, DEPTH=5, AF_LEVEL=3, AE_LEVEL=2: write 0x0011 -> data_out=0x0011 the next cycle with no rd_en. Fill to 5 -> almostfull high at counts 3-4. Seven write/read wrap cycles preserve order across the pointer wrap.
- Fill to 4, assert rst_n=0 for one cycle with wr_en=1 -> count=0, empty=1, no wr_ack. The subsequent first read returns the first post-reset write.
